// File: rtl/inst_mem_loader.sv
// Program loader: assembles a little-endian byte stream into 32-bit words and
// writes them to instruction memory, then hands the memory address port back to the core.
module inst_mem_loader #(
  parameter int XLEN      = 32,
  parameter int ILEN      = 32,
  parameter int MEM_WORDS = 256
) (
  input  logic            clock,
  input  logic            reset,
  input  logic            start,
  input  logic [8:0]      length,
  input  logic            byte_valid,
  input  logic [7:0]      byte_data,
  output logic            byte_ready,
  input  logic [XLEN-1:0] core_pc,
  output logic [XLEN-1:0] mem_addr,
  output logic [ILEN-1:0] mem_wdata,
  output logic            mem_write_en,
  output logic            busy,
  output logic            done,
  output logic            error,
  output logic [1:0]      fsm_state
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_LOAD  = 2'd1,
    S_WRITE = 2'd2,
    S_DONE  = 2'd3
  } state_t;

  localparam logic [9:0] MAX_LEN = 10'(MEM_WORDS);

  // Byte handshake: a byte moves only in a cycle where byte_valid && byte_ready;
  // byte_ready is a pure state decode, so the source may hold or drop byte_valid freely.

  state_t      state;
  state_t      state_next;
  logic [8:0]  word_cnt;
  logic [1:0]  byte_cnt;
  logic [31:0] asm_reg;
  logic [8:0]  len_q;
  logic        error_q;
  logic        len_ok;
  logic        last_word;

  assign len_ok    = (length != 9'd0) && ({1'b0, length} <= MAX_LEN);
  assign last_word = (({1'b0, word_cnt} + 10'd1) == {1'b0, len_q});

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state <= S_IDLE;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next = state;
    case (state)
      S_IDLE:  if (start && len_ok) state_next = S_LOAD;
      S_LOAD:  if (byte_valid && (byte_cnt == 2'd3)) state_next = S_WRITE;
      S_WRITE: state_next = last_word ? S_DONE : S_LOAD;
      S_DONE:  state_next = S_IDLE;
      default: state_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      word_cnt <= '0;
      byte_cnt <= '0;
      asm_reg  <= '0;
      len_q    <= '0;
      error_q  <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          if (start) begin
            if (len_ok) begin
              len_q    <= length;
              word_cnt <= '0;
              byte_cnt <= '0;
              asm_reg  <= '0;
              error_q  <= 1'b0;
            end else begin
              error_q  <= 1'b1;
            end
          end
        end
        S_LOAD: begin
          if (byte_valid) begin
            asm_reg[8*byte_cnt +: 8] <= byte_data;
            byte_cnt                 <= byte_cnt + 2'd1;
          end
        end
        S_WRITE: begin
          if (!last_word) word_cnt <= word_cnt + 9'd1;
        end
        default: ;
      endcase
    end
  end

  // The core_pc path is only selected outside LOAD/WRITE, so the core never sees its own
  // fetch address on the memory port while a load owns it.
  always_comb begin
    mem_addr     = core_pc;
    mem_wdata    = '0;
    mem_write_en = 1'b0;
    byte_ready   = 1'b0;
    busy         = 1'b0;
    done         = 1'b0;
    case (state)
      S_LOAD: begin
        mem_addr   = XLEN'({word_cnt, 2'b00});
        byte_ready = 1'b1;
        busy       = 1'b1;
      end
      S_WRITE: begin
        mem_addr     = XLEN'({word_cnt, 2'b00});
        mem_wdata    = ILEN'(asm_reg);
        mem_write_en = 1'b1;
        busy         = 1'b1;
      end
      S_DONE:  done = 1'b1;
      default: ;
    endcase
  end

  assign error     = error_q;
  assign fsm_state = state;

endmodule

// File: tb/tb_inst_mem_loader.sv
// Bench for inst_mem_loader: drives byte-stream loads and checks the memory writes,
// timing, error flag and reset behaviour against a word-level model of the program.
module tb_inst_mem_loader;

  logic        clock;
  logic        reset;
  logic        start;
  logic [8:0]  length;
  logic        byte_valid;
  logic [7:0]  byte_data;
  logic        byte_ready;
  logic [31:0] core_pc;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic        mem_write_en;
  logic        busy;
  logic        done;
  logic        error;
  logic [1:0]  fsm_state;

  inst_mem_loader #(.XLEN(32), .ILEN(32), .MEM_WORDS(256)) dut (
    .clock(clock), .reset(reset), .start(start), .length(length),
    .byte_valid(byte_valid), .byte_data(byte_data), .byte_ready(byte_ready),
    .core_pc(core_pc), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_write_en(mem_write_en), .busy(busy), .done(done), .error(error),
    .fsm_state(fsm_state)
  );

  // clock / reset
  initial clock = 1'b0;
  always #5 clock = ~clock;

  int tests_run = 0;
  int tests_failed = 0;

  logic [7:0]  prog [0:1023];
  logic [63:0] exp_q[$];
  logic [63:0] got_q[$];

  int cyc = 0;
  int start_cyc = 0;
  int done_cnt = 0;
  int done_cyc = 0;
  int busy_cnt = 0;
  int first_wr = -1;
  int wr_total = 0;
  int ready_viol = 0;
  int pc_viol = 0;
  bit timed_out = 0;

  always @(posedge clock) cyc <= cyc + 1;

  // monitor: samples outputs on the falling edge
  always @(negedge clock) begin
    if (mem_write_en) begin
      got_q.push_back({mem_addr, mem_wdata});
      wr_total++;
      if (first_wr < 0) first_wr = cyc;
      if (byte_ready) ready_viol++;
    end
    if (done) begin
      done_cnt++;
      done_cyc = cyc;
    end
    if (busy) busy_cnt++;
    if (busy && (mem_addr == core_pc)) pc_viol++;
    if (!busy && (mem_addr !== core_pc)) pc_viol++;
  end

  // model: word k is bytes 4k..4k+3 little-endian, written at byte address 4k
  function automatic void build_exp(input int len);
    exp_q.delete();
    for (int k = 0; k < len; k++)
      exp_q.push_back({32'(k * 4), prog[4*k+3], prog[4*k+2], prog[4*k+1], prog[4*k]});
  endfunction

  // driver: mode 0 = valid held high, 1 = toggling, 2 = random
  task automatic run_load(input int len, input int mode, input bit inject);
    int idx;
    int guard;
    int nbytes;
    bit tog;
    got_q.delete();
    done_cnt = 0; busy_cnt = 0; first_wr = -1; timed_out = 0;
    nbytes = len * 4;
    @(posedge clock); #1;
    start = 1'b1; length = 9'(len); start_cyc = cyc; core_pc = $urandom;
    @(posedge clock); #1;
    start = 1'b0; length = 9'($urandom_range(0, 511));
    idx = 0; guard = 0; tog = 1'b1;
    while (idx < nbytes && guard < nbytes * 4 + 40) begin
      case (mode)
        0: byte_valid = 1'b1;
        1: begin byte_valid = tog; tog = !tog; end
        default: byte_valid = 1'($urandom_range(0, 1));
      endcase
      byte_data = prog[idx];
      if (inject && guard == 3) begin
        start = 1'b1; length = 9'(len + 1);
      end else begin
        start = 1'b0;
      end
      core_pc = $urandom;
      @(negedge clock);
      if (byte_valid && byte_ready) idx++;
      @(posedge clock); #1;
      guard++;
    end
    byte_valid = 1'b0; start = 1'b0;
    guard = 0;
    while (done_cnt == 0 && guard < 30) begin
      core_pc = $urandom;
      @(posedge clock); #1;
      guard++;
    end
    if (idx < nbytes || done_cnt == 0) timed_out = 1'b1;
    repeat (2) @(posedge clock);
    #1;
  endtask

  task automatic fill_random;
    for (int i = 0; i < 1024; i++) prog[i] = 8'($urandom);
  endtask

  task automatic test_reset;
    reset = 1'b1; start = 1'b0; length = '0; byte_valid = 1'b0; byte_data = '0;
    core_pc = 32'h1234_5678;
    repeat (3) @(posedge clock);
    @(negedge clock);
    tests_run++; if (byte_ready !== 1'b0) begin tests_failed++; $display("FAIL reset byte_ready: got %b expected 0", byte_ready); end
    tests_run++; if (mem_write_en !== 1'b0) begin tests_failed++; $display("FAIL reset mem_write_en: got %b expected 0", mem_write_en); end
    tests_run++; if (busy !== 1'b0) begin tests_failed++; $display("FAIL reset busy: got %b expected 0", busy); end
    tests_run++; if (done !== 1'b0) begin tests_failed++; $display("FAIL reset done: got %b expected 0", done); end
    tests_run++; if (error !== 1'b0) begin tests_failed++; $display("FAIL reset error: got %b expected 0", error); end
    tests_run++; if (mem_wdata !== 32'h0) begin tests_failed++; $display("FAIL reset mem_wdata: got %h expected 0", mem_wdata); end
    tests_run++; if (mem_addr !== 32'h1234_5678) begin tests_failed++; $display("FAIL reset mem_addr: got %h expected 12345678", mem_addr); end
    @(posedge clock); #1;
    reset = 1'b0;
    repeat (2) @(posedge clock);
    #1;
  endtask

  task automatic test_two_words;
    logic [7:0] p [0:7];
    p = '{8'h13, 8'h00, 8'h00, 8'h00, 8'h93, 8'h00, 8'h10, 8'h00};
    for (int i = 0; i < 8; i++) prog[i] = p[i];
    exp_q.delete();
    exp_q.push_back({32'd0, 32'h0000_0013});
    exp_q.push_back({32'd4, 32'h0010_0093});
    run_load(2, 0, 1'b0);
    tests_run++; if (timed_out) begin tests_failed++; $display("FAIL two_words timeout: load did not complete"); end
    tests_run++; if (got_q.size() !== exp_q.size()) begin tests_failed++; $display("FAIL two_words count: got %0d expected %0d", got_q.size(), exp_q.size()); end
    for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
      tests_run++;
      if (got_q[i] !== exp_q[i]) begin tests_failed++; $display("FAIL two_words write %0d: got %h expected %h", i, got_q[i], exp_q[i]); end
    end
    tests_run++; if (done_cyc - start_cyc !== 11) begin tests_failed++; $display("FAIL two_words done_cycle: got %0d expected 11", done_cyc - start_cyc); end
    tests_run++; if (busy_cnt !== 10) begin tests_failed++; $display("FAIL two_words busy_cycles: got %0d expected 10", busy_cnt); end
    tests_run++; if (first_wr - start_cyc !== 5) begin tests_failed++; $display("FAIL two_words first_write_cycle: got %0d expected 5", first_wr - start_cyc); end
    tests_run++; if (done_cnt !== 1) begin tests_failed++; $display("FAIL two_words done_pulses: got %0d expected 1", done_cnt); end
  endtask

  task automatic test_toggle;
    fill_random();
    build_exp(1);
    run_load(1, 1, 1'b0);
    tests_run++; if (timed_out) begin tests_failed++; $display("FAIL toggle timeout: load did not complete"); end
    tests_run++; if (got_q.size() !== 1) begin tests_failed++; $display("FAIL toggle count: got %0d expected 1", got_q.size()); end
    if (got_q.size() > 0) begin
      tests_run++;
      if (got_q[0] !== exp_q[0]) begin tests_failed++; $display("FAIL toggle word: got %h expected %h", got_q[0], exp_q[0]); end
    end
    tests_run++; if (ready_viol !== 0) begin tests_failed++; $display("FAIL toggle ready_in_write: got %0d expected 0", ready_viol); end
  endtask

  task automatic test_error;
    int w0;
    w0 = wr_total;
    busy_cnt = 0;
    @(negedge clock);
    tests_run++; if (error !== 1'b0) begin tests_failed++; $display("FAIL error initial: got %b expected 0", error); end
    for (int k = 0; k < 3; k++) begin
      @(posedge clock); #1;
      start = 1'b1;
      length = (k == 0) ? 9'd0 : (k == 1) ? 9'd300 : 9'd257;
      @(posedge clock); #1;
      start = 1'b0;
      repeat (3) @(negedge clock);
      tests_run++; if (error !== 1'b1) begin tests_failed++; $display("FAIL error flag len=%0d: got %b expected 1", length, error); end
    end
    tests_run++; if (wr_total !== w0) begin tests_failed++; $display("FAIL error writes: got %0d expected 0", wr_total - w0); end
    tests_run++; if (busy_cnt !== 0) begin tests_failed++; $display("FAIL error busy_cycles: got %0d expected 0", busy_cnt); end
    fill_random();
    build_exp(1);
    run_load(1, 0, 1'b0);
    tests_run++; if (timed_out) begin tests_failed++; $display("FAIL error_clear timeout: load did not complete"); end
    tests_run++; if (error !== 1'b0) begin tests_failed++; $display("FAIL error_clear flag: got %b expected 0", error); end
    tests_run++; if (got_q.size() !== 1) begin tests_failed++; $display("FAIL error_clear count: got %0d expected 1", got_q.size()); end
    if (got_q.size() > 0) begin
      tests_run++;
      if (got_q[0] !== exp_q[0]) begin tests_failed++; $display("FAIL error_clear word: got %h expected %h", got_q[0], exp_q[0]); end
    end
  endtask

  task automatic test_full;
    int viol0;
    for (int i = 0; i < 1024; i++) prog[i] = 8'(i);
    build_exp(256);
    run_load(256, 0, 1'b0);
    tests_run++; if (timed_out) begin tests_failed++; $display("FAIL full timeout: load did not complete"); end
    tests_run++; if (got_q.size() !== 256) begin tests_failed++; $display("FAIL full count: got %0d expected 256", got_q.size()); end
    for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
      tests_run++;
      if (got_q[i] !== exp_q[i]) begin tests_failed++; $display("FAIL full write %0d: got %h expected %h", i, got_q[i], exp_q[i]); end
    end
    if (got_q.size() > 0) begin
      tests_run++;
      if (got_q[got_q.size()-1][63:32] !== 32'd1020) begin tests_failed++; $display("FAIL full last_addr: got %0d expected 1020", got_q[got_q.size()-1][63:32]); end
    end
    tests_run++; if (done_cnt !== 1) begin tests_failed++; $display("FAIL full done_pulses: got %0d expected 1", done_cnt); end
    viol0 = pc_viol;
    for (int i = 0; i < 5; i++) begin
      core_pc = $urandom;
      @(negedge clock);
      tests_run++;
      if (mem_addr !== core_pc) begin tests_failed++; $display("FAIL full pc_track: got %h expected %h", mem_addr, core_pc); end
      @(posedge clock); #1;
    end
    tests_run++; if (pc_viol !== 0) begin tests_failed++; $display("FAIL full addr_mux: got %0d bad cycles expected 0", pc_viol); end
  endtask

  task automatic test_mid_reset;
    int idx;
    int guard;
    fill_random();
    got_q.delete();
    @(posedge clock); #1;
    start = 1'b1; length = 9'd3; core_pc = 32'hCAFE_0001;
    @(posedge clock); #1;
    start = 1'b0;
    idx = 0; guard = 0; byte_valid = 1'b1;
    while (idx < 6 && guard < 40) begin
      byte_data = prog[idx];
      @(negedge clock);
      if (byte_valid && byte_ready) idx++;
      @(posedge clock); #1;
      guard++;
    end
    byte_valid = 1'b0;
    tests_run++; if (idx != 6) begin tests_failed++; $display("FAIL mid_reset timeout: got %0d bytes expected 6", idx); end
    #2 reset = 1'b1;
    #1;
    tests_run++; if (busy !== 1'b0) begin tests_failed++; $display("FAIL mid_reset busy: got %b expected 0", busy); end
    tests_run++; if (byte_ready !== 1'b0) begin tests_failed++; $display("FAIL mid_reset byte_ready: got %b expected 0", byte_ready); end
    tests_run++; if (mem_addr !== core_pc) begin tests_failed++; $display("FAIL mid_reset mem_addr: got %h expected %h", mem_addr, core_pc); end
    tests_run++; if (mem_write_en !== 1'b0) begin tests_failed++; $display("FAIL mid_reset mem_write_en: got %b expected 0", mem_write_en); end
    build_exp(1);
    tests_run++; if (got_q.size() !== 1) begin tests_failed++; $display("FAIL mid_reset count: got %0d expected 1", got_q.size()); end
    if (got_q.size() > 0) begin
      tests_run++;
      if (got_q[0] !== exp_q[0]) begin tests_failed++; $display("FAIL mid_reset word0: got %h expected %h", got_q[0], exp_q[0]); end
    end
    @(posedge clock); #1;
    reset = 1'b0;
    fill_random();
    build_exp(1);
    run_load(1, 0, 1'b0);
    tests_run++; if (timed_out) begin tests_failed++; $display("FAIL mid_reset restart timeout: load did not complete"); end
    tests_run++; if (got_q.size() !== 1) begin tests_failed++; $display("FAIL mid_reset restart count: got %0d expected 1", got_q.size()); end
    if (got_q.size() > 0) begin
      tests_run++;
      if (got_q[0] !== exp_q[0]) begin tests_failed++; $display("FAIL mid_reset restart word: got %h expected %h", got_q[0], exp_q[0]); end
    end
  endtask

  task automatic test_start_ignored;
    fill_random();
    build_exp(3);
    run_load(3, 2, 1'b1);
    tests_run++; if (timed_out) begin tests_failed++; $display("FAIL start_ignored timeout: load did not complete"); end
    tests_run++; if (got_q.size() !== 3) begin tests_failed++; $display("FAIL start_ignored count: got %0d expected 3", got_q.size()); end
    for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
      tests_run++;
      if (got_q[i] !== exp_q[i]) begin tests_failed++; $display("FAIL start_ignored write %0d: got %h expected %h", i, got_q[i], exp_q[i]); end
    end
    tests_run++; if (done_cnt !== 1) begin tests_failed++; $display("FAIL start_ignored done_pulses: got %0d expected 1", done_cnt); end
  endtask

  task automatic test_random;
    int len;
    int mode;
    for (int t = 0; t < 6; t++) begin
      fill_random();
      len = $urandom_range(1, 12);
      mode = $urandom_range(0, 2);
      build_exp(len);
      run_load(len, mode, 1'b0);
      tests_run++; if (timed_out) begin tests_failed++; $display("FAIL random%0d timeout: load did not complete", t); end
      tests_run++; if (got_q.size() !== len) begin tests_failed++; $display("FAIL random%0d count: got %0d expected %0d", t, got_q.size(), len); end
      for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
        tests_run++;
        if (got_q[i] !== exp_q[i]) begin tests_failed++; $display("FAIL random%0d write %0d: got %h expected %h", t, i, got_q[i], exp_q[i]); end
      end
    end
    tests_run++; if (ready_viol !== 0) begin tests_failed++; $display("FAIL random ready_in_write: got %0d expected 0", ready_viol); end
    tests_run++; if (pc_viol !== 0) begin tests_failed++; $display("FAIL random addr_mux: got %0d bad cycles expected 0", pc_viol); end
  endtask

  initial begin
    test_reset();
    test_two_words();
    test_toggle();
    test_error();
    test_start_ignored();
    test_random();
    test_full();
    test_mid_reset();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule

// File: doc/inst_mem_loader.md
INST_MEM_LOADER -- requirements
Module: inst_mem_loader

Interface
REQ-001 SHALL have parameter XLEN, default 32, address width of the instruction memory port.
REQ-002 SHALL have parameter ILEN, default 32, instruction/word width; fixed at 4 bytes.
REQ-003 SHALL have parameter MEM_WORDS, default 256, instruction memory capacity in words (1024 bytes).
REQ-004 SHALL have port clock  input  1  single clock; all state updates on its rising edge.
REQ-005 SHALL have port reset  input  1  asynchronous, active-high reset.
REQ-006 SHALL have port start  input  1  single-cycle request to begin a program load.
REQ-007 SHALL have port length  input  9  number of words to load; sampled when start is accepted.
REQ-008 SHALL have port byte_valid  input  1  byte stream source has a byte on byte_data.
REQ-009 SHALL have port byte_data  input  8  program byte, little-endian within each word.
REQ-010 SHALL have port byte_ready  output  1  loader accepts byte_data this cycle.
REQ-011 SHALL have port core_pc  input  XLEN  fetch address from the core.
REQ-012 SHALL have port mem_addr  output  XLEN  address to instruction memory (pc port).
REQ-013 SHALL have port mem_wdata  output  ILEN  write data to instruction memory.
REQ-014 SHALL have port mem_write_en  output  1  write strobe to instruction memory.
REQ-015 SHALL have port busy  output  1  load in progress; core shall stall fetch while high.
REQ-016 SHALL have port done  output  1  one-cycle pulse at load completion.
REQ-017 SHALL have port error  output  1  sticky flag: last start had an illegal length.

Function
REQ-018 SHALL implement states IDLE, LOAD, WRITE, DONE.
REQ-019 IDLE: mem_addr = core_pc, mem_write_en = 0, byte_ready = 0, busy = 0.
REQ-020 IDLE + start + 1 <= length <= MEM_WORDS: latch length, clear word_cnt and byte_cnt, clear error, go to LOAD next cycle.
REQ-021 IDLE + start + (length == 0 or length > MEM_WORDS): set error, stay in IDLE, no memory write.
REQ-022 LOAD: byte_ready = 1, busy = 1, mem_write_en = 0; a byte is accepted only on byte_valid && byte_ready.
REQ-023 Accepted byte SHALL be stored in lane byte_cnt of the assembly register (lane 0 = bits 7:0), then byte_cnt increments modulo 4.
REQ-024 Acceptance of lane 3 SHALL move to WRITE next cycle; byte_valid low in LOAD causes no state change (stall of any length is legal).
REQ-025 WRITE: exactly one cycle, byte_ready = 0, mem_write_en = 1, mem_addr = zero-extended {word_cnt, 2'b00}, mem_wdata = assembly register.
REQ-026 After WRITE: if word_cnt + 1 == latched length go to DONE, else increment word_cnt and return to LOAD.
REQ-027 DONE: done = 1 for one cycle, busy = 0, mem_addr = core_pc; next state IDLE.
REQ-028 While busy = 1, mem_addr SHALL never equal core_pc by selection; the core_pc path is fully muxed out.
REQ-029 start while not in IDLE SHALL be ignored; length changes after acceptance SHALL have no effect.
REQ-030 word_cnt SHALL be 9 bits; highest address written is (MEM_WORDS-1)*4 = 1020; no wrap-around is possible.
REQ-031 Latency for N words with byte_valid held high: 5N cycles from first LOAD cycle to DONE, first mem_write_en in the 5th LOAD/WRITE cycle.
REQ-032 Outputs SHALL be registered state decodes or muxes of registered state and core_pc only; byte_ready SHALL not depend combinationally on byte_valid.

Reset
REQ-033 reset high SHALL immediately force IDLE, word_cnt = 0, byte_cnt = 0, assembly register = 0, error = 0.
REQ-034 During reset: byte_ready = 0, mem_write_en = 0, busy = 0, done = 0, mem_wdata = 0, mem_addr = core_pc.
REQ-035 reset mid-load SHALL abort without a further write; words already written stay in memory; partially assembled word is discarded.

Verification
REQ-036 length=2, bytes 13 00 00 00 93 00 10 00 with byte_valid held high -> writes 0x00000013 @0, 0x00100093 @4, done pulse on cycle 11 after start, busy high 10 cycles.
REQ-037 length=1, byte_valid toggling 1,0,1,0,... -> single write of the correctly assembled word; no byte lost or duplicated; byte_ready low during WRITE.
REQ-038 start with length=0, then length=300 -> error=1, no mem_write_en, busy stays 0; following start with length=1 clears error.
REQ-039 length=256, incrementing byte pattern -> last write at mem_addr 1020, done asserted once, then mem_addr tracks core_pc.
REQ-040 reset asserted after 2 bytes of word 1 of a 3-word load -> outputs at reset values asynchronously, only word 0 written, subsequent start restarts at address 0.
REQ-041 start pulsed during LOAD with different length -> ignored; original length completes.
